// File: rtl/phys_regfile_mp_pkg.sv
// Shared R10K sizing constants and index helpers for the multi-ported
// physical register file.
package phys_regfile_mp_pkg;
   localparam int DATA_W           = 32;
   localparam int PHYS_REG_SZ_R10K = 64;
   localparam int PHYS_REG_IDX     = $clog2(PHYS_REG_SZ_R10K);
   localparam int RF_ZERO_IDX      = 0;

   typedef logic [DATA_W-1:0]       data_t;
   typedef logic [PHYS_REG_IDX-1:0] phys_reg_idx_t;

   function automatic logic idx_valid(input phys_reg_idx_t idx, input int depth);
      return (int'(idx) < depth);
   endfunction

   function automatic logic idx_is_zero(input phys_reg_idx_t idx, input logic zero_en);
      return zero_en && (int'(idx) == RF_ZERO_IDX);
   endfunction
endpackage

// File: rtl/phys_regfile_mp_resolve.sv
// Combinational resolution of all write and allocate ports into per-entry
// set/clear masks, winning write data and a port-conflict indication.
module rf_write_resolve
   import phys_regfile_mp_pkg::*;
#(
   parameter int WIDTH       = DATA_W,
   parameter int DEPTH       = PHYS_REG_SZ_R10K,
   parameter int WRITE_PORTS = 2,
   parameter int CLR_PORTS   = 2,
   parameter int ZERO_IDX_EN = 1
) (
   input  logic [WRITE_PORTS-1:0]              we,
   input  logic [WRITE_PORTS*PHYS_REG_IDX-1:0] waddr,
   input  logic [WRITE_PORTS*WIDTH-1:0]        wdata,
   input  logic [CLR_PORTS-1:0]                clr,
   input  logic [CLR_PORTS*PHYS_REG_IDX-1:0]   caddr,
   output logic [DEPTH-1:0]                    set_mask,
   output logic [DEPTH-1:0]                    clr_mask,
   output logic [DEPTH-1:0][WIDTH-1:0]         win_data,
   output logic                                conflict
);
   phys_reg_idx_t widx;
   phys_reg_idx_t cidx;

   // Ascending port order lets a higher-index write overwrite (and flag) a lower one.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      win_data = '0;
      conflict = 1'b0;
      widx     = '0;
      cidx     = '0;
      for (int j = 0; j < WRITE_PORTS; j++) begin
         widx = waddr[j*PHYS_REG_IDX +: PHYS_REG_IDX];
         if (we[j] && !idx_is_zero(widx, ZERO_IDX_EN != 0) && idx_valid(widx, DEPTH)) begin
            conflict       = conflict | set_mask[widx];
            set_mask[widx] = 1'b1;
            win_data[widx] = wdata[j*WIDTH +: WIDTH];
         end else if (we[j] && !idx_is_zero(widx, ZERO_IDX_EN != 0)) begin
            conflict = 1'b1;
         end else begin
            conflict = conflict;
         end
      end
      for (int k = 0; k < CLR_PORTS; k++) begin
         cidx = caddr[k*PHYS_REG_IDX +: PHYS_REG_IDX];
         if (clr[k] && !idx_is_zero(cidx, ZERO_IDX_EN != 0) && idx_valid(cidx, DEPTH)) begin
            clr_mask[cidx] = 1'b1;
         end else if (clr[k] && !idx_is_zero(cidx, ZERO_IDX_EN != 0)) begin
            conflict = 1'b1;
         end else begin
            conflict = conflict;
         end
      end
      conflict = conflict | (|(set_mask & clr_mask));
   end
endmodule

// File: rtl/phys_regfile_mp.sv
// Multi-ported physical register file with per-entry ready bits, same-cycle
// forwarding, optional registered read and a sticky port-conflict flag.
module phys_regfile_mp
   import phys_regfile_mp_pkg::*;
#(
   parameter int WIDTH        = DATA_W,
   parameter int DEPTH        = PHYS_REG_SZ_R10K,
   parameter int READ_PORTS   = 4,
   parameter int WRITE_PORTS  = 2,
   parameter int CLR_PORTS    = 2,
   parameter int BYPASS_EN    = 1,
   parameter int READ_LATENCY = 0,
   parameter int ZERO_IDX_EN  = 1
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic [READ_PORTS-1:0]               re,
   input  logic [READ_PORTS*PHYS_REG_IDX-1:0]  raddr,
   output logic [READ_PORTS*WIDTH-1:0]         rdata,
   output logic [READ_PORTS-1:0]               rready,
   input  logic [WRITE_PORTS-1:0]              we,
   input  logic [WRITE_PORTS*PHYS_REG_IDX-1:0] waddr,
   input  logic [WRITE_PORTS*WIDTH-1:0]        wdata,
   input  logic [CLR_PORTS-1:0]                clr,
   input  logic [CLR_PORTS*PHYS_REG_IDX-1:0]   caddr,
   output logic                                err
);
   logic [DEPTH-1:0][WIDTH-1:0] mem_q;
   logic [DEPTH-1:0]            rdy_q;
   logic                        err_q;
   logic [DEPTH-1:0]            set_mask;
   logic [DEPTH-1:0]            clr_mask;
   logic [DEPTH-1:0][WIDTH-1:0] win_data;
   logic                        wr_conflict;
   logic [READ_PORTS*WIDTH-1:0] rd_data_d;
   logic [READ_PORTS-1:0]       rd_rdy_d;
   logic                        rd_oor;
   phys_reg_idx_t               ridx;

   rf_write_resolve #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .WRITE_PORTS (WRITE_PORTS),
      .CLR_PORTS   (CLR_PORTS),
      .ZERO_IDX_EN (ZERO_IDX_EN)
   ) u_resolve (
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .clr      (clr),
      .caddr    (caddr),
      .set_mask (set_mask),
      .clr_mask (clr_mask),
      .win_data (win_data),
      .conflict (wr_conflict)
   );

   // Read mux: range check, hardwired zero entry, forwarding, then stored state.
   always_comb begin
      rd_data_d = '0;
      rd_rdy_d  = '0;
      rd_oor    = 1'b0;
      ridx      = '0;
      for (int i = 0; i < READ_PORTS; i++) begin
         ridx = raddr[i*PHYS_REG_IDX +: PHYS_REG_IDX];
         if (!re[i]) begin
            rd_rdy_d[i] = 1'b0;
         end else if (!idx_valid(ridx, DEPTH)) begin
            rd_oor = 1'b1;
         end else if (idx_is_zero(ridx, ZERO_IDX_EN != 0)) begin
            rd_rdy_d[i] = 1'b1;
         end else if ((BYPASS_EN != 0) && set_mask[ridx]) begin
            rd_data_d[i*WIDTH +: WIDTH] = win_data[ridx];
            rd_rdy_d[i]                 = !clr_mask[ridx];
         end else begin
            rd_data_d[i*WIDTH +: WIDTH] = mem_q[ridx];
            rd_rdy_d[i]                 = rdy_q[ridx];
         end
      end
   end

   // Storage update: clear beats set for ready, data is written regardless.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         mem_q <= '0;
         rdy_q <= '1;
         err_q <= 1'b0;
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            if (set_mask[e]) mem_q[e] <= win_data[e];
            if (clr_mask[e])      rdy_q[e] <= 1'b0;
            else if (set_mask[e]) rdy_q[e] <= 1'b1;
         end
         err_q <= err_q | wr_conflict | rd_oor;
      end
   end

   assign err = err_q;

   generate
      if (READ_LATENCY != 0) begin : g_rd_reg
         logic [READ_PORTS*WIDTH-1:0] rd_data_q;
         logic [READ_PORTS-1:0]       rd_rdy_q;

         // One-cycle read pipeline; reset flushes whatever was in flight.
         always_ff @(posedge clock) begin
            if (!reset_n) begin
               rd_data_q <= '0;
               rd_rdy_q  <= '0;
            end else begin
               rd_data_q <= rd_data_d;
               rd_rdy_q  <= rd_rdy_d;
            end
         end

         assign rdata  = rd_data_q;
         assign rready = rd_rdy_q;
      end else begin : g_rd_comb
         assign rdata  = rd_data_d;
         assign rready = rd_rdy_d;
      end
   endgenerate
endmodule

// File: tb/tb_phys_regfile_mp.sv
// Randomised and directed bench for phys_regfile_mp: three configurations
// (bypass/comb, no-bypass/comb, bypass/registered with non-power-of-two depth).
module tb_phys_regfile_mp;
   localparam int RP = 4;
   localparam int WP = 2;
   localparam int CP = 2;
   localparam int IW = 6;
   localparam int W  = 32;

   logic            clock;
   logic            reset_n;
   logic [RP-1:0]   re;
   logic [RP*IW-1:0] raddr;
   logic [WP-1:0]   we;
   logic [WP*IW-1:0] waddr;
   logic [WP*W-1:0] wdata;
   logic [CP-1:0]   clr;
   logic [CP*IW-1:0] caddr;

   logic [RP*W-1:0] rdata_a, rdata_b, rdata_c;
   logic [RP-1:0]   rready_a, rready_b, rready_c;
   logic            err_a, err_b, err_c;

   // Reference state: cfg 0 = 64 entries, cfg 1 = 48 entries.
   logic [31:0] m_data [2][64];
   logic        m_rdy  [2][64];
   logic        m_err  [2];
   logic [31:0] exp_c_data [RP];
   logic        exp_c_rdy  [RP];

   int n_cmp = 0;
   int n_bad = 0;

   phys_regfile_mp #(.BYPASS_EN(1), .READ_LATENCY(0)) dut_a (
      .clock(clock), .reset_n(reset_n), .re(re), .raddr(raddr), .rdata(rdata_a),
      .rready(rready_a), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
      .caddr(caddr), .err(err_a));

   phys_regfile_mp #(.BYPASS_EN(0), .READ_LATENCY(0)) dut_b (
      .clock(clock), .reset_n(reset_n), .re(re), .raddr(raddr), .rdata(rdata_b),
      .rready(rready_b), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
      .caddr(caddr), .err(err_b));

   phys_regfile_mp #(.DEPTH(48), .BYPASS_EN(1), .READ_LATENCY(1)) dut_c (
      .clock(clock), .reset_n(reset_n), .re(re), .raddr(raddr), .rdata(rdata_c),
      .rready(rready_c), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
      .caddr(caddr), .err(err_c));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected same-cycle read result from the rules, not the RTL structure.
   function automatic void model_read(input int cfg, input bit bypass, input int p,
                                      output logic [31:0] d, output logic r);
      int depth = (cfg != 0) ? 48 : 64;
      int a     = int'(raddr[p*IW +: IW]);
      bit hit   = 1'b0;
      bit hc    = 1'b0;
      d = 32'h0;
      r = 1'b0;
      if (!re[p] || a >= depth) return;
      if (a == 0) begin
         r = 1'b1;
         return;
      end
      for (int j = 0; j < WP; j++)
         if (we[j] && int'(waddr[j*IW +: IW]) == a) begin
            hit = 1'b1;
            d   = wdata[j*W +: W];
         end
      for (int k = 0; k < CP; k++)
         if (clr[k] && int'(caddr[k*IW +: IW]) == a) hc = 1'b1;
      if (bypass && hit) begin
         r = !hc;
      end else begin
         d = m_data[cfg][a];
         r = m_rdy[cfg][a];
      end
   endfunction

   function automatic void model_edge(input int cfg);
      int depth = (cfg != 0) ? 48 : 64;
      if (!reset_n) begin
         for (int a = 0; a < 64; a++) begin
            m_data[cfg][a] = 32'h0;
            m_rdy[cfg][a]  = 1'b1;
         end
         m_err[cfg] = 1'b0;
         return;
      end
      for (int p = 0; p < RP; p++)
         if (re[p] && int'(raddr[p*IW +: IW]) >= depth) m_err[cfg] = 1'b1;
      for (int j = 0; j < WP; j++)
         if (we[j] && int'(waddr[j*IW +: IW]) >= depth) m_err[cfg] = 1'b1;
      for (int k = 0; k < CP; k++)
         if (clr[k] && int'(caddr[k*IW +: IW]) >= depth) m_err[cfg] = 1'b1;
      for (int a = 1; a < depth; a++) begin
         int          nw;
         bit          hc;
         logic [31:0] d;
         nw = 0;
         hc = 1'b0;
         d  = 32'h0;
         for (int j = 0; j < WP; j++)
            if (we[j] && int'(waddr[j*IW +: IW]) == a) begin
               nw++;
               d = wdata[j*W +: W];
            end
         for (int k = 0; k < CP; k++)
            if (clr[k] && int'(caddr[k*IW +: IW]) == a) hc = 1'b1;
         if (nw > 1 || (nw > 0 && hc)) m_err[cfg] = 1'b1;
         if (nw > 0) begin
            m_data[cfg][a] = d;
            m_rdy[cfg][a]  = 1'b1;
         end
         if (hc) m_rdy[cfg][a] = 1'b0;
      end
   endfunction

   task automatic check_all();
      logic [31:0] d;
      logic        r;
      for (int p = 0; p < RP; p++) begin
         model_read(0, 1'b1, p, d, r);
         chk($sformatf("a_rdata%0d", p), rdata_a[p*W +: W], d);
         chk($sformatf("a_rready%0d", p), 32'(rready_a[p]), 32'(r));
         model_read(0, 1'b0, p, d, r);
         chk($sformatf("b_rdata%0d", p), rdata_b[p*W +: W], d);
         chk($sformatf("b_rready%0d", p), 32'(rready_b[p]), 32'(r));
         chk($sformatf("c_rdata%0d", p), rdata_c[p*W +: W], exp_c_data[p]);
         chk($sformatf("c_rready%0d", p), 32'(rready_c[p]), 32'(exp_c_rdy[p]));
      end
      chk("a_err", 32'(err_a), 32'(m_err[0]));
      chk("b_err", 32'(err_b), 32'(m_err[0]));
      chk("c_err", 32'(err_c), 32'(m_err[1]));
   endtask

   // Check at negedge+2, then advance DUT and model across one posedge.
   task automatic tick();
      logic [31:0] d;
      logic        r;
      #2;
      check_all();
      @(posedge clock);
      for (int p = 0; p < RP; p++) begin
         model_read(1, 1'b1, p, d, r);
         exp_c_data[p] = reset_n ? d : 32'h0;
         exp_c_rdy[p]  = reset_n ? r : 1'b0;
      end
      model_edge(0);
      model_edge(1);
      @(negedge clock);
   endtask

   task automatic idle();
      reset_n = 1'b1;
      re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0; clr = '0; caddr = '0;
   endtask

   task automatic do_reset();
      idle();
      reset_n = 1'b0;
      tick();
      idle();
   endtask

   task automatic rd(input int p, input int a);
      re[p] = 1'b1;
      raddr[p*IW +: IW] = IW'(a);
   endtask

   task automatic wr(input int j, input int a, input logic [31:0] d);
      we[j] = 1'b1;
      waddr[j*IW +: IW] = IW'(a);
      wdata[j*W +: W] = d;
   endtask

   task automatic cl(input int k, input int a);
      clr[k] = 1'b1;
      caddr[k*IW +: IW] = IW'(a);
   endtask

   function automatic logic [IW-1:0] rand_addr();
      int r = $urandom_range(0, 99);
      if (r < 3)  return IW'($urandom_range(48, 63));
      if (r < 8)  return '0;
      if (r < 50) return IW'($urandom_range(1, 7));
      return IW'($urandom_range(1, 47));
   endfunction

   initial begin
      idle();
      reset_n = 1'b0;
      @(posedge clock);
      model_edge(0);
      model_edge(1);
      for (int p = 0; p < RP; p++) begin
         exp_c_data[p] = 32'h0;
         exp_c_rdy[p]  = 1'b0;
      end
      @(negedge clock);
      idle();

      // Every entry reads zero and ready after reset.
      for (int g = 0; g < 16; g++) begin
         for (int p = 0; p < RP; p++) rd(p, g*4 + p);
         #1;
         for (int p = 0; p < RP; p++) begin
            chk("t1_rdata", rdata_a[p*W +: W], 32'h0);
            chk("t1_rready", 32'(rready_a[p]), 32'h1);
         end
         chk("t1_err", 32'(err_a), 32'h0);
         tick();
      end

      // Allocate clear, then forwarding vs non-forwarding of a new write.
      do_reset();
      cl(0, 5);
      tick();
      idle();
      rd(0, 5);
      #1;
      chk("t2_clr_rready", 32'(rready_a[0]), 32'h0);
      tick();
      idle();
      wr(0, 5, 32'hDEADBEEF);
      rd(0, 5);
      #1;
      chk("t2_byp_rdata", rdata_a[31:0], 32'hDEADBEEF);
      chk("t2_byp_rready", 32'(rready_a[0]), 32'h1);
      chk("t2_nobyp_rdata", rdata_b[31:0], 32'h0);
      chk("t2_nobyp_rready", 32'(rready_b[0]), 32'h0);
      tick();
      idle();
      rd(0, 5);
      #1;
      chk("t2_nobyp_next_rdata", rdata_b[31:0], 32'hDEADBEEF);
      chk("t2_nobyp_next_rready", 32'(rready_b[0]), 32'h1);
      chk("t2_lat_rdata", rdata_c[31:0], 32'hDEADBEEF);
      tick();

      // Same-address double write: highest port wins, error sticks.
      do_reset();
      wr(0, 9, 32'h11);
      wr(1, 9, 32'h22);
      tick();
      idle();
      rd(3, 9);
      #1;
      chk("t3_rdata", rdata_a[3*W +: W], 32'h22);
      chk("t3_err", 32'(err_a), 32'h1);
      tick();
      idle();
      tick();
      tick();
      #1;
      chk("t3_err_sticky", 32'(err_a), 32'h1);
      tick();
      do_reset();
      #1;
      chk("t3_err_reset", 32'(err_a), 32'h0);
      tick();

      // Clear and write together: data lands, ready stays low, error raised.
      do_reset();
      wr(0, 12, 32'h12345678);
      cl(1, 12);
      tick();
      idle();
      rd(1, 12);
      #1;
      chk("t4_rdata", rdata_a[1*W +: W], 32'h12345678);
      chk("t4_rready", 32'(rready_a[1]), 32'h0);
      chk("t4_err", 32'(err_a), 32'h1);
      tick();

      // Registered read: one cycle latency, flushed by reset.
      do_reset();
      wr(0, 3, 32'hA5);
      tick();
      idle();
      rd(2, 3);
      tick();
      idle();
      #1;
      chk("t5_lat_rdata", rdata_c[2*W +: W], 32'hA5);
      chk("t5_lat_rready", 32'(rready_c[2]), 32'h1);
      tick();
      rd(2, 3);
      reset_n = 1'b0;
      tick();
      idle();
      #1;
      chk("t5_rst_rdata", rdata_c[2*W +: W], 32'h0);
      chk("t5_rst_rready", 32'(rready_c[2]), 32'h0);
      tick();

      // Zero entry ignores write/clear and raises no error.
      do_reset();
      wr(0, 0, 32'h55);
      cl(0, 0);
      rd(0, 0);
      #1;
      chk("t6_rdata_same", rdata_a[31:0], 32'h0);
      chk("t6_rready_same", 32'(rready_a[0]), 32'h1);
      tick();
      idle();
      rd(0, 0);
      #1;
      chk("t6_rdata", rdata_a[31:0], 32'h0);
      chk("t6_rready", 32'(rready_a[0]), 32'h1);
      chk("t6_err", 32'(err_a), 32'h0);
      tick();

      // Random traffic with occasional resets.
      for (int c = 0; c < 500; c++) begin
         reset_n = ($urandom_range(0, 24) != 0);
         re  = RP'($urandom);
         we  = WP'($urandom);
         clr = CP'($urandom_range(0, 3) == 0 ? $urandom : 0);
         for (int p = 0; p < RP; p++) raddr[p*IW +: IW] = rand_addr();
         for (int j = 0; j < WP; j++) begin
            waddr[j*IW +: IW] = rand_addr();
            wdata[j*W +: W]   = $urandom;
         end
         for (int k = 0; k < CP; k++) caddr[k*IW +: IW] = rand_addr();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
